dsp_slice_arbiter: RTL and testbench

Shares one DSP48A1 multiply/accumulate slice among up to NUM_CLIENTS ALU clients (alu_taylor_calc, filter and envelope ALUs). Each client drives the flat DSP port bundle {opmode[7:0], a[17:0], b[17:0]} and reads {m[35:0], p[47:0]}. The arbiter grants exclusive ownership for a whole calculation, with round-robin fairness. Between owners it drains the pipeline with NOPs so that no client consumes another client's M/P results.

---
 rtl/dsp_slice_arbiter_pkg.sv | 21 ++
 rtl/rr_priority_pick.sv | 32 +++
 rtl/dsp_slice_arbiter.sv | 147 ++++++++++++++
 tb/tb_dsp_slice_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_slice_arbiter_pkg.sv
// Shared types and constants for the DSP slice arbiter and its round-robin picker.
// The DSP port bundle widths and the NOP bundle are reused by every ALU client.
package dsp_slice_arbiter_pkg;

  localparam int DSP_INS_W  = 44;  // {opmode[7:0], a[17:0], b[17:0]}
  localparam int DSP_OUTS_W = 84;  // {m[35:0], p[47:0]}

  localparam logic [7:0]           DSP_NOP_OPMODE = 8'h00;
  localparam logic [DSP_INS_W-1:0] DSP_NOP_INS    = {DSP_NOP_OPMODE, 18'h0, 18'h0};

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN   = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_e;

  function automatic int wrap_inc(input int value, input int modulus);
    return (value + 1) % modulus;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin selector: first eligible bit at or above ptr, wrapping.
// Shared with the voice allocator, so it carries no arbiter-specific state.
module rr_priority_pick #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     eligible,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     pick,
  output logic [PTR_W-1:0] pick_idx,
  output logic             valid
);

  logic [PTR_W-1:0] idx;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    valid    = 1'b0;
    idx      = '0;
    for (int k = 0; k < N; k++) begin
      idx = PTR_W'((int'(ptr) + k) % N);
      if (!valid && eligible[idx]) begin
        valid     = 1'b1;
        pick[idx] = 1'b1;
        pick_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/dsp_slice_arbiter.sv
// Grants one shared DSP48A1 slice to a client for a whole calculation, round-robin,
// and drains the M/P pipeline with NOPs between owners so results never leak across.
module dsp_slice_arbiter
  import dsp_slice_arbiter_pkg::*;
#(
  parameter int NUM_CLIENTS     = 4,
  parameter int DRAIN_CYCLES    = 3,
  parameter int MAX_HOLD_CYCLES = 1024
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_CLIENTS-1:0]           req,
  output logic [NUM_CLIENTS-1:0]           grant,
  input  logic [DSP_INS_W*NUM_CLIENTS-1:0] cl_dsp_ins_flat,
  output logic [DSP_OUTS_W-1:0]            cl_dsp_outs_flat,
  output logic [DSP_INS_W-1:0]             dsp_ins_flat,
  input  logic [DSP_OUTS_W-1:0]            dsp_outs_flat,
  output logic                             hold_timeout_err
);

  localparam int PTR_W   = $clog2(NUM_CLIENTS);
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int HOLD_W  = (MAX_HOLD_CYCLES > 1) ? $clog2(MAX_HOLD_CYCLES) : 1;
  localparam bit WDOG_EN = (MAX_HOLD_CYCLES != 0);

  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'((MAX_HOLD_CYCLES > 0) ? MAX_HOLD_CYCLES - 1 : 0);

  arb_state_e             state, state_n;
  logic [NUM_CLIENTS-1:0] grant_n, revoked, revoked_n, revoke_set, eligible, pick;
  logic [PTR_W-1:0]       owner, owner_n, rr_ptr, rr_ptr_n, pick_idx;
  logic [HOLD_W-1:0]      hold_cnt, hold_cnt_n;
  logic [DRAIN_W-1:0]     drain_cnt, drain_cnt_n;
  logic                   err_n, pick_valid, owner_req, timeout;

  assign eligible  = req & ~revoked;
  assign owner_req = req[owner];
  assign timeout   = WDOG_EN && (hold_cnt == HOLD_LAST);

  rr_priority_pick #(
    .N     (NUM_CLIENTS),
    .PTR_W (PTR_W)
  ) u_pick (
    .eligible (eligible),
    .ptr      (rr_ptr),
    .pick     (pick),
    .pick_idx (pick_idx),
    .valid    (pick_valid)
  );

  always_comb begin
    state_n     = state;
    grant_n     = grant;
    owner_n     = owner;
    rr_ptr_n    = rr_ptr;
    hold_cnt_n  = hold_cnt;
    drain_cnt_n = drain_cnt;
    err_n       = hold_timeout_err;
    revoke_set  = '0;

    case (state)
      ARB_IDLE: begin
        if (pick_valid) begin
          grant_n    = pick;
          owner_n    = pick_idx;
          hold_cnt_n = '0;
          state_n    = ARB_OWN;
        end
      end

      ARB_OWN: begin
        hold_cnt_n = hold_cnt + 1'b1;
        // A dropped request wins over a timeout landing on the same cycle.
        if (!owner_req || timeout) begin
          grant_n     = '0;
          rr_ptr_n    = PTR_W'(wrap_inc(int'(owner), NUM_CLIENTS));
          drain_cnt_n = '0;
          state_n     = ARB_DRAIN;
          if (owner_req) begin
            err_n      = 1'b1;
            revoke_set = grant;
          end
        end
      end

      ARB_DRAIN: begin
        drain_cnt_n = drain_cnt + 1'b1;
        if (drain_cnt == DRAIN_LAST) begin
          state_n = ARB_IDLE;
          if (pick_valid) begin
            grant_n    = pick;
            owner_n    = pick_idx;
            hold_cnt_n = '0;
            state_n    = ARB_OWN;
          end
        end
      end

      default: begin
        state_n = ARB_IDLE;
        grant_n = '0;
      end
    endcase

    // A revoked client is released only once it has let go of req.
    revoked_n = (revoked & req) | revoke_set;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= ARB_IDLE;
      grant            <= '0;
      owner            <= '0;
      rr_ptr           <= '0;
      hold_cnt         <= '0;
      drain_cnt        <= '0;
      revoked          <= '0;
      hold_timeout_err <= 1'b0;
    end else begin
      state            <= state_n;
      grant            <= grant_n;
      owner            <= owner_n;
      rr_ptr           <= rr_ptr_n;
      hold_cnt         <= hold_cnt_n;
      drain_cnt        <= drain_cnt_n;
      revoked          <= revoked_n;
      hold_timeout_err <= err_n;
    end
  end

  // Unregistered so a client's issue-to-M latency is the same as owning the slice directly.
  always_comb begin
    dsp_ins_flat = DSP_NOP_INS;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (grant[i]) dsp_ins_flat = cl_dsp_ins_flat[DSP_INS_W*i +: DSP_INS_W];
    end
  end

  assign cl_dsp_outs_flat = dsp_outs_flat;

  a_grant_onehot0: assert property (@(posedge clk) disable iff (!reset) $onehot0(grant));

  a_owner_stable: assert property (@(posedge clk) disable iff (!reset)
    (state == ARB_OWN && owner_req && !timeout) |=> $stable(grant));

endmodule

// File: tb/tb_dsp_slice_arbiter.sv
// Scoreboard bench for dsp_slice_arbiter: stimulus queues expected grants and
// cycle-tagged values; a negedge monitor pops and compares them.
module tb_dsp_slice_arbiter;
  import dsp_slice_arbiter_pkg::*;

  localparam int N    = 4;
  localparam int MAXH = 16;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [N-1:0]           req;
  logic [N-1:0]           grant;
  logic [DSP_INS_W*N-1:0] cl_ins;
  logic [DSP_OUTS_W-1:0]  cl_outs, dsp_outs;
  logic [DSP_INS_W-1:0]   dsp_ins;
  logic                   err;

  always #5 clk = ~clk;

  dsp_slice_arbiter #(
    .NUM_CLIENTS     (N),
    .DRAIN_CYCLES    (3),
    .MAX_HOLD_CYCLES (MAXH)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req              (req),
    .grant            (grant),
    .cl_dsp_ins_flat  (cl_ins),
    .cl_dsp_outs_flat (cl_outs),
    .dsp_ins_flat     (dsp_ins),
    .dsp_outs_flat    (dsp_outs),
    .hold_timeout_err (err)
  );

  typedef enum {K_GRANT, K_INS, K_ERR, K_OUTS} kind_e;
  typedef struct {
    int           cyc;
    kind_e        kind;
    logic [83:0]  val;
    string        name;
  } exp_t;
  typedef struct {
    int owner;
    int gap;
  } own_t;

  exp_t exp_q[$];
  own_t own_q[$];

  int cyc    = 0;
  int n_cmp  = 0;
  int n_fail = 0;
  int g;
  int rr_order[5];
  logic [83:0] outs_pattern;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [83:0] act, input logic [83:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [43:0] bundle(input int i);
    return {8'(1 + i), 18'(18'h10000 + i), 18'(18'h08000 + i)};
  endfunction

  task automatic expect_at(input int c, input kind_e k, input logic [83:0] v, input string nm);
    exp_t e;
    int   pos;
    e.cyc  = c;
    e.kind = k;
    e.val  = v;
    e.name = nm;
    pos = exp_q.size();
    while (pos > 0 && exp_q[pos-1].cyc > c) pos--;
    exp_q.insert(pos, e);
  endtask

  task automatic expect_owner(input int o, input int gap);
    own_t r;
    r.owner = o;
    r.gap   = gap;
    own_q.push_back(r);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: cycle-tagged values plus every new ownership event.
  logic [N-1:0] prev_grant = '0;
  int           zero_run   = 0;
  exp_t         cur;
  own_t         o;
  logic [83:0]  act;

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      cur = exp_q.pop_front();
      case (cur.kind)
        K_GRANT: act = 84'(grant);
        K_INS:   act = 84'(dsp_ins);
        K_ERR:   act = 84'(err);
        default: act = cl_outs;
      endcase
      check($sformatf("%s@%0d", cur.name, cur.cyc), act, cur.val);
    end
    check($sformatf("onehot0@%0d", cyc), 84'($onehot0(grant)), 84'(1));
    if (grant != '0 && grant != prev_grant) begin
      if (prev_grant != '0) check($sformatf("overlap@%0d", cyc), 84'(prev_grant), 84'(0));
      if (own_q.size() == 0) begin
        check($sformatf("unexpected_grant@%0d", cyc), 84'(grant), 84'(0));
      end else begin
        o = own_q.pop_front();
        check($sformatf("owner@%0d", cyc), 84'(grant), 84'(1) << o.owner);
        if (o.gap >= 0) check($sformatf("gap@%0d", cyc), 84'(zero_run), 84'(o.gap));
      end
      zero_run = 0;
    end else if (grant == '0) begin
      zero_run++;
    end
    prev_grant = grant;
  end

  initial begin
    reset    = 1'b0;
    req      = '0;
    dsp_outs = '0;
    for (int i = 0; i < N; i++) cl_ins[DSP_INS_W*i +: DSP_INS_W] = bundle(i);
    rr_order = '{0, 1, 2, 3, 0};
    outs_pattern = {36'hA_BCDE_F012, 48'h3456_789A_BCDE};

    expect_at(1, K_GRANT, 0, "rst_grant");
    expect_at(1, K_INS, DSP_NOP_INS, "rst_ins");
    expect_at(1, K_ERR, 0, "rst_err");
    wait_until(2);
    reset = 1'b1;

    // Single client, 1-cycle grant latency, 3 NOP cycles after release.
    wait_until(10);
    req = 4'b0001;
    expect_owner(0, -1);
    expect_at(10, K_GRANT, 0, "t1_pre");
    expect_at(11, K_GRANT, 4'b0001, "t1_grant");
    expect_at(11, K_INS, bundle(0), "t1_ins");
    wait_until(12);
    dsp_outs = outs_pattern;
    expect_at(12, K_OUTS, outs_pattern, "t1_outs");
    wait_until(20);
    req = '0;
    expect_at(20, K_GRANT, 4'b0001, "t1_last");
    for (int c = 21; c <= 23; c++) begin
      expect_at(c, K_GRANT, 0, "t1_drain_grant");
      expect_at(c, K_INS, DSP_NOP_INS, "t1_drain_ins");
    end
    expect_at(24, K_GRANT, 0, "t1_idle");

    // Reset between tests puts rr_ptr back to 0.
    wait_until(30);
    reset = 1'b0;
    wait_until(32);
    reset = 1'b1;

    // Round robin with all clients requesting, 5-cycle ownerships.
    wait_until(40);
    req = '1;
    for (int k = 0; k < 5; k++) expect_owner(rr_order[k], (k == 0) ? -1 : 3);
    g = 41;
    for (int k = 0; k < 5; k++) begin
      expect_at(g, K_GRANT, 84'(1) << rr_order[k], "rr_first");
      expect_at(g, K_INS, bundle(rr_order[k]), "rr_ins");
      expect_at(g + 4, K_GRANT, 84'(1) << rr_order[k], "rr_last");
      expect_at(g + 5, K_GRANT, 0, "rr_drop");
      expect_at(g + 7, K_INS, DSP_NOP_INS, "rr_nop");
      wait_until(g + 4);
      req = (k == 4) ? '0 : (req & ~(4'(1) << rr_order[k]));
      if (k < 4) begin
        wait_until(g + 5);
        req[rr_order[k]] = 1'b1;
      end
      g += 8;
    end

    // Pointer wrap: client 2 finishes (ptr=3), then 0101 picks 0 before 2.
    wait_until(90);
    req = 4'b0100;
    expect_owner(2, -1);
    expect_at(91, K_GRANT, 4'b0100, "ptr_c2");
    wait_until(94);
    req = '0;
    wait_until(100);
    req = 4'b0101;
    expect_owner(0, -1);
    expect_owner(2, 3);
    expect_at(101, K_GRANT, 4'b0001, "ptr_wrap_c0");
    wait_until(104);
    req = 4'b0100;
    expect_at(109, K_GRANT, 4'b0100, "ptr_then_c2");
    wait_until(112);
    req = '0;
    expect_at(113, K_GRANT, 0, "ptr_release");

    // Watchdog: client 1 holds forever, revoked after 16 cycles; client 3 waits.
    wait_until(120);
    req = 4'b0010;
    expect_owner(1, -1);
    expect_owner(3, 3);
    expect_at(121, K_GRANT, 4'b0010, "wd_grant");
    wait_until(125);
    req[3] = 1'b1;
    expect_at(136, K_GRANT, 4'b0010, "wd_hold16");
    expect_at(136, K_ERR, 0, "wd_err_before");
    expect_at(137, K_GRANT, 0, "wd_revoke");
    expect_at(137, K_ERR, 1, "wd_err_set");
    expect_at(140, K_GRANT, 4'b1000, "wd_c3");
    wait_until(144);
    req[3] = 1'b0;
    expect_at(145, K_GRANT, 0, "wd_c3_drop");
    expect_at(150, K_GRANT, 0, "wd_no_regrant");
    expect_at(150, K_ERR, 1, "wd_err_sticky");
    wait_until(152);
    req[1] = 1'b0;
    wait_until(153);
    req[1] = 1'b1;
    expect_owner(1, -1);
    expect_at(153, K_GRANT, 0, "wd_cleared_wait");
    expect_at(154, K_GRANT, 4'b0010, "wd_regrant");
    expect_at(154, K_ERR, 1, "wd_err_still");
    wait_until(156);
    req = '0;
    expect_at(157, K_GRANT, 0, "wd_c1_drop");

    // Reset mid-ownership: grant and DSP inputs drop without a clock edge.
    wait_until(170);
    req = 4'b0100;
    expect_owner(2, -1);
    expect_at(171, K_GRANT, 4'b0100, "rst_own");
    expect_at(171, K_INS, bundle(2), "rst_own_ins");
    wait_until(174);
    reset = 1'b0;
    req   = '0;
    expect_at(174, K_GRANT, 0, "rst_async_grant");
    expect_at(174, K_INS, DSP_NOP_INS, "rst_async_ins");
    expect_at(174, K_ERR, 0, "rst_async_err");
    wait_until(176);
    reset = 1'b1;
    wait_until(180);
    req = 4'b0110;
    expect_owner(1, -1);
    expect_at(181, K_GRANT, 4'b0010, "rst_ptr0_c1");
    expect_at(181, K_INS, bundle(1), "rst_ptr0_ins");
    wait_until(185);
    req = '0;
    expect_at(186, K_GRANT, 0, "final_release");

    wait_until(195);
    check("pending_values", 84'(exp_q.size()), 84'(0));
    check("pending_grants", 84'(own_q.size()), 84'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
